circle_hit_counter: RTL and testbench

- Sequencer for a time-shared squaring datapath that counts how many of a batch of 2**W sampled (x, y) points fall strictly inside the circle x²+y² < R2.
- Drives one start-of-conversion strobe to both ADCs, waits for both end-of-conversion flags, and latches the two signed 8-bit samples.
- Computes x² and y² over two cycles with a single squarer (mul_add_nat, N=M=8) and compares the 16-bit sum against R2.
- After 2**W samples it presents the hit count to the consumer over a dav_/rfd handshake, then starts the next batch.

---
 rtl/circle_hit_counter.sv | 125 ++++++++++++
 tb/tb_circle_hit_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/circle_hit_counter.sv
// Batch hit counter for sampled (x, y) points: sequences two ADCs, squares each sample on
// a single shared multiply-add unit, and reports how many points fall strictly inside R2.

module mul_add_nat #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  input  logic [N+M-1:0] c,
  output logic [N+M-1:0] p
);
  assign p = {{M{1'b0}}, a} * {{N{1'b0}}, b} + c;
endmodule

module circle_hit_counter #(
  parameter int          W  = 4,
  parameter logic [15:0] R2 = 16'd4097
) (
  input  logic         clock,
  input  logic         reset_,
  output logic         soc,
  input  logic         eoc_x,
  input  logic         eoc_y,
  input  logic [7:0]   x,
  input  logic [7:0]   y,
  output logic         dav_,
  input  logic         rfd,
  output logic [W:0]   hits
);

  typedef enum logic [2:0] {
    S_SOC, S_EOC, S_SQX, S_SQY, S_CMP, S_WRDY, S_DAV, S_ACK
  } state_t;

  state_t       star, star_next;
  logic [7:0]   x_reg, y_reg;
  logic [15:0]  acc, sum;
  logic [W-1:0] cnt;
  logic [W:0]   hits_reg, hits_inc;
  logic [7:0]   sq_in;
  logic [15:0]  sq_add, sq_out;
  logic         hit, last;

  // -128 maps to 128, which still fits the unsigned 8-bit squarer input.
  function automatic logic [7:0] abs8(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  always_comb begin
    sq_in  = abs8(x_reg);
    sq_add = 16'd0;
    if (star == S_SQY) begin
      sq_in  = abs8(y_reg);
      sq_add = acc;
    end
  end

  mul_add_nat #(.N(8), .M(8)) u_sq (
    .a (sq_in),
    .b (sq_in),
    .c (sq_add),
    .p (sq_out)
  );

  assign hit      = (sum < R2);
  assign hits_inc = hits_reg + (W+1)'(hit);
  assign last     = (cnt == {W{1'b1}});

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    star_next = star;
    case (star)
      S_SOC:   if (!eoc_x && !eoc_y) star_next = S_EOC;
      S_EOC:   if (eoc_x && eoc_y)   star_next = S_SQX;
      S_SQX:   star_next = S_SQY;
      S_SQY:   star_next = S_CMP;
      S_CMP:   star_next = last ? S_WRDY : S_SOC;
      S_WRDY:  if (rfd)  star_next = S_DAV;
      S_DAV:   if (!rfd) star_next = S_ACK;
      S_ACK:   star_next = S_SOC;
      default: star_next = S_SOC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      star     <= S_SOC;
      soc      <= 1'b0;
      dav_     <= 1'b1;
      hits     <= '0;
      cnt      <= '0;
      hits_reg <= '0;
    end else begin
      star <= star_next;
      case (star)
        S_SOC: soc <= 1'b1;
        S_EOC: soc <= 1'b0;
        S_CMP: begin
          hits_reg <= hits_inc;
          cnt      <= cnt + W'(1);
          if (last) hits <= hits_inc;
        end
        S_DAV: dav_ <= 1'b0;
        S_ACK: begin
          dav_     <= 1'b1;
          hits_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are always written before being consumed.
  always_ff @(posedge clock) begin
    if (star == S_EOC && eoc_x && eoc_y) begin
      x_reg <= x;
      y_reg <= y;
    end
    if (star == S_SQX) acc <= sq_out;
    if (star == S_SQY) sum <= sq_out;
  end

endmodule

// File: tb/tb_circle_hit_counter.sv
// Scoreboard bench: an ADC model feeds queued samples, expected batch counts are queued as
// batches are launched and popped when the DUT presents dav_.

module tb_circle_hit_counter;

  logic              clock = 1'b0;
  logic              reset_;
  logic              soc, eoc_x, eoc_y, dav_, rfd;
  logic signed [7:0] x, y;
  logic [4:0]        hits;

  logic              soc2, eoc2, dav2, rfd2;
  logic [7:0]        xy2;
  logic [2:0]        hits2;

  int checks   = 0;
  int failures = 0;

  int sx[$], sy[$], exp_q[$];
  int batch_acc;
  int adc_taken = 0;
  int gap_mode  = 0;
  int soc2_pulses = 0;
  logic soc2_prev = 1'b0;

  always #5 clock = ~clock;

  circle_hit_counter #(.W(4), .R2(16'd4097)) u_dut (
    .clock(clock), .reset_(reset_), .soc(soc), .eoc_x(eoc_x), .eoc_y(eoc_y),
    .x(x), .y(y), .dav_(dav_), .rfd(rfd), .hits(hits)
  );

  circle_hit_counter #(.W(2), .R2(16'd4097)) u_dut2 (
    .clock(clock), .reset_(reset_), .soc(soc2), .eoc_x(eoc2), .eoc_y(eoc2),
    .x(xy2), .y(xy2), .dav_(dav2), .rfd(rfd2), .hits(hits2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sq_abs(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return a * a;
  endfunction

  task automatic add(input int vx, input int vy);
    sx.push_back(vx);
    sy.push_back(vy);
    if (sq_abs(vx) + sq_abs(vy) < 4097) batch_acc++;
  endtask

  task automatic close_batch();
    exp_q.push_back(batch_acc);
    batch_acc = 0;
  endtask

  task automatic report(input string tag);
    int n = 0;
    int e;
    while (dav_ !== 1'b0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (dav_ !== 1'b0) begin
      check({tag, "_dav_timeout"}, 0, 1);
      return;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    check({tag, "_hits"}, int'(hits), e);
    rfd = 1'b0;
    @(negedge clock); check({tag, "_dav_hold"}, int'(dav_), 0);
    @(negedge clock); check({tag, "_dav_release"}, int'(dav_), 1);
    @(negedge clock); check({tag, "_soc_rearm"}, int'(soc), 1);
    rfd = 1'b1;
  endtask

  task automatic wait_taken(input int target);
    int n = 0;
    while (adc_taken < target && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("adc_progress", int'(adc_taken >= target), 1);
  endtask

  // ADC pair model: drops eoc on soc, then presents the next queued sample once soc falls.
  initial begin
    int vx, vy, junk;
    eoc_x = 1'b1; eoc_y = 1'b1; x = '0; y = '0;
    forever begin
      @(negedge clock);
      if (soc && eoc_x && eoc_y) begin
        eoc_x = 1'b0; eoc_y = 1'b0;
        do @(negedge clock); while (soc);
        while (sx.size() == 0) @(negedge clock);
        vx = sx.pop_front();
        vy = sy.pop_front();
        if (gap_mode != 0) begin
          junk  = (vx == 0) ? 100 : 0;
          x     = 8'(junk);
          y     = 8'(vy);
          eoc_x = 1'b1;
          repeat (2) @(negedge clock);
          x = 8'(junk + 1);
          repeat (3) @(negedge clock);
        end
        x = 8'(vx);
        y = 8'(vy);
        eoc_x = 1'b1;
        eoc_y = 1'b1;
        adc_taken++;
      end
    end
  end

  initial begin
    xy2  = 8'h80;
    eoc2 = 1'b1;
    forever begin
      @(negedge clock);
      eoc2 = ~soc2;
      if (soc2 && !soc2_prev) soc2_pulses++;
      soc2_prev = soc2;
    end
  end

  initial begin
    repeat (60000) @(posedge clock);
    check("global_timeout", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int target = 0;
    int n, snap;
    batch_acc = 0;
    reset_ = 1'b0; rfd = 1'b1; rfd2 = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_soc", int'(soc), 0);
    check("rst_dav", int'(dav_), 1);
    check("rst_hits", int'(hits), 0);
    check("rst_hits_w2", int'(hits2), 0);
    reset_ = 1'b1;
    @(negedge clock);
    check("soc_first_edge", int'(soc), 1);

    for (int i = 0; i < 16; i++) add(0, 0);
    close_batch();
    target += 16;
    report("all_hit");

    add(64, 0); add(0, -64); add(64, 1); add(-128, -128);
    for (int i = 0; i < 12; i++) add(1, 127);
    close_batch();
    target += 16;
    report("boundary");

    gap_mode = 1;
    for (int i = 0; i < 16; i++) add((i % 4 == 3) ? 100 : 0, 0);
    close_batch();
    target += 16;
    report("eoc_gap");
    gap_mode = 0;

    rfd = 1'b0;
    for (int i = 0; i < 16; i++) add((i < 8) ? -64 : 127, (i < 8) ? 0 : 127);
    close_batch();
    target += 16;
    wait_taken(target);
    repeat (10) @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      check("park_dav", int'(dav_), 1);
      check("park_soc", int'(soc), 0);
      check("park_hits", int'(hits), exp_q[0]);
      @(negedge clock);
    end
    rfd = 1'b1;
    report("park");

    for (int i = 0; i < 16; i++) add(0, 0);
    close_batch();
    wait_taken(target + 9);
    sx.delete(); sy.delete(); exp_q.delete();
    reset_ = 1'b0;
    @(negedge clock);
    check("midrst_soc", int'(soc), 0);
    check("midrst_dav", int'(dav_), 1);
    check("midrst_hits", int'(hits), 0);
    reset_ = 1'b1;
    for (int i = 0; i < 16; i++) add(0, 0);
    close_batch();
    report("after_reset");

    snap = 0;
    for (int b = 0; b < 4; b++) begin
      rfd2 = 1'b1;
      n = 0;
      while (dav2 !== 1'b0 && n < 500) begin
        @(negedge clock);
        n++;
      end
      check("w2_dav_low", int'(dav2), 0);
      check("w2_hits", int'(hits2), 0);
      if (b > 0) check("w2_samples_per_batch", soc2_pulses - snap, 4);
      snap = soc2_pulses;
      rfd2 = 1'b0;
      n = 0;
      while (dav2 !== 1'b1 && n < 50) begin
        @(negedge clock);
        n++;
      end
      check("w2_dav_release", int'(dav2), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
